load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access engine of rysyCore.
- Takes load/store requests from the execute stage and drives a valid/ready memory bus.
- Extracts, aligns and sign/zero-extends load data, then presents it as rd_mem to the writeback selector.
- Raises busy so the core stalls while an access is outstanding.

Parameters:
MAX_WAIT, 255, bus wait cycles allowed (mem_valid high, mem_ready low) before the access is abandoned; 1..255.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  start an access; sampled only in IDLE
we  in  1  1 = store, 0 = load
funct3  in  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  REG_LEN  byte address
wdata  in  REG_LEN  store data, taken from low bits
busy  out  1  access in progress
done  out  1  one-cycle completion pulse
err  out  1  qualifies done: misaligned, illegal funct3 or timeout
rd_mem  out  REG_LEN  extended load result, held until the next successful load
mem_valid  out  1  bus request
mem_ready  in  1  bus accept/response; read data valid in the same cycle
mem_we  out  1  bus write enable
mem_addr  out  REG_LEN  word address; low two bits always 0
mem_wstrb  out  4  byte-lane enables; 0 on reads
mem_wdata  out  REG_LEN  lane-replicated store data
mem_rdata  in  REG_LEN  read word

Behaviour:
- REG_LEN is 32 (from rysyPkg).
- Reset (async, rst_n low) clears every output to 0, including rd_mem, and puts the FSM in IDLE. Asserting reset mid-access drops mem_valid immediately, with no done pulse.
- FSM states: IDLE, BUS, RESP.
- IDLE with req=1:
  - Register we, funct3, addr[1:0], mem_addr = {addr[31:2],2'b00}, and the strobe/data.
  - Set busy=1 the next cycle.
  - Legal access: go to BUS with mem_valid=1.
  - Illegal access: go to RESP with err pending and no bus cycle.
- An access is illegal when:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - funct3 is 011, 110 or 111;
  - a store with funct3[2]=1.
- BUS state:
  - mem_valid stays high; mem_we, mem_addr, mem_wstrb and mem_wdata stay stable until the handshake.
  - The handshake is mem_valid && mem_ready. On that cycle, loads capture the extracted mem_rdata into rd_mem. Go to RESP.
  - A wait counter starts at 0 on BUS entry and increments each cycle mem_ready=0.
  - When the counter equals MAX_WAIT and mem_ready is still 0: drop mem_valid, go to RESP with err pending, leave rd_mem unchanged.
  - If ready arrives on the same cycle as the timeout, the handshake wins.
- RESP state: done=1 for exactly one cycle, err per result, busy=0 on that same cycle, then IDLE.
- req is ignored while busy=1. req asserted on the done cycle is also ignored; it is accepted on the following cycle.
- Store strobes and data:
  - B: wstrb = 1<<addr[1:0], byte replicated across 4 lanes.
  - H: wstrb = 0011 or 1100 by addr[1], halfword replicated across 2 lanes.
  - W: wstrb = 1111.
- Load extraction:
  - Select the byte lane by addr[1:0], or the halfword by addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Latency: req in cycle N gives mem_valid in N+1. Ready in cycle M gives done in M+1. Minimum req-to-done is 2 cycles; an illegal access also takes 2 cycles.
- rd_mem changes only on a successful load handshake. Stores and errors never alter it.

Test Plan:
- Reset then LW addr=0x100 with ready in the same cycle as valid, mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, wstrb=0;
  - done at req+2, err=0, rd_mem=0xDEADBEEF.
- mem_rdata=0x80FF7F01:
  - LB addr=0x103 -> rd_mem=0xFFFFFF80;
  - LBU addr=0x103 -> 0x00000080;
  - LH addr=0x102 -> 0xFFFF80FF;
  - LHU addr=0x100 -> 0x00007F01.
- SB addr=0x201 wdata=0x12345678 -> mem_addr=0x200, wstrb=0010, mem_wdata=0x78787878.
- SH addr=0x202 -> wstrb=1100, mem_wdata=0x56785678.
- Hold ready low for 3 cycles -> mem_addr/mem_wdata/wstrb remain stable and no done fires before ready.
- LW addr=0x102 -> no mem_valid ever, done+err at req+2, rd_mem keeps its previous value.
- SB with funct3=100 -> same error response as the misaligned LW.
- MAX_WAIT=4, ready tied low:
  - mem_valid drops after 4 wait cycles, then done+err.
  - Repeat with ready arriving exactly on the timeout cycle -> success, err=0.
- Pulse rst_n low while in BUS -> mem_valid=0 and busy=0 asynchronously, no done. A new req after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store engine: issues one valid/ready bus access per request, and
// aligns and extends load data into rd_mem for writeback.
module load_store_unit #(
  parameter  int MAX_WAIT = 255,
  localparam int REG_LEN  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [REG_LEN-1:0] addr,
  input  logic [REG_LEN-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [REG_LEN-1:0] rd_mem,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic               mem_we,
  output logic [REG_LEN-1:0] mem_addr,
  output logic [3:0]         mem_wstrb,
  output logic [REG_LEN-1:0] mem_wdata,
  input  logic [REG_LEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t               state_reg, state_next;
  logic                 we_reg, we_next;
  logic [2:0]           funct3_reg, funct3_next;
  logic [1:0]           lane_reg, lane_next;
  logic [7:0]           wait_reg, wait_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic [REG_LEN-1:0]   rd_mem_reg, rd_mem_next;
  logic                 mem_valid_reg, mem_valid_next;
  logic                 mem_we_reg, mem_we_next;
  logic [REG_LEN-1:0]   mem_addr_reg, mem_addr_next;
  logic [3:0]           mem_wstrb_reg, mem_wstrb_next;
  logic [REG_LEN-1:0]   mem_wdata_reg, mem_wdata_next;

  logic                 illegal;
  logic [3:0]           strb_req;
  logic [REG_LEN-1:0]   wdata_rep;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [REG_LEN-1:0]   load_data;

  // Legality of the incoming request: alignment, encoding, and no unsigned stores.
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr[0];
      3'b010:         illegal = (addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
    if (we && funct3[2]) illegal = 1'b1;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        strb_req  = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_req  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        strb_req  = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    if (!we) strb_req = 4'b0000;
  end

  always_comb begin
    case (lane_reg)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    funct3_next    = funct3_reg;
    lane_next      = lane_reg;
    wait_next      = wait_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    rd_mem_next    = rd_mem_reg;
    mem_valid_next = mem_valid_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wstrb_next = mem_wstrb_reg;
    mem_wdata_next = mem_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          we_next        = we;
          funct3_next    = funct3;
          lane_next      = addr[1:0];
          wait_next      = 8'd0;
          busy_next      = 1'b1;
          mem_we_next    = we;
          mem_addr_next  = {addr[REG_LEN-1:2], 2'b00};
          mem_wstrb_next = strb_req;
          mem_wdata_next = wdata_rep;
          if (illegal) begin
            state_next     = RESP;
            mem_valid_next = 1'b0;
          end else begin
            state_next     = BUS;
            mem_valid_next = 1'b1;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          if (!we_reg) rd_mem_next = load_data;
          mem_valid_next = 1'b0;
          done_next      = 1'b1;
          busy_next      = 1'b0;
          state_next     = RESP;
        end else if (wait_reg == 8'(MAX_WAIT)) begin
          mem_valid_next = 1'b0;
          done_next      = 1'b1;
          err_next       = 1'b1;
          busy_next      = 1'b0;
          state_next     = RESP;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      RESP: begin
        // An illegal access spends its first RESP cycle busy, so it also
        // reports two cycles after the request.
        if (!done_reg) begin
          done_next = 1'b1;
          err_next  = 1'b1;
          busy_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      lane_reg      <= 2'd0;
      wait_reg      <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rd_mem_reg    <= '0;
      mem_valid_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wstrb_reg <= 4'd0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      funct3_reg    <= funct3_next;
      lane_reg      <= lane_next;
      wait_reg      <= wait_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      rd_mem_reg    <= rd_mem_next;
      mem_valid_reg <= mem_valid_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wstrb_reg <= mem_wstrb_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign rd_mem    = rd_mem_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single accesses plus
// hand sequences for req-on-done and reset mid-access.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rd_mem;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rd_mem(rd_mem), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;     // valid cycles before ready; -1 = never
    logic        e_err;
    int          e_done;  // cycles from req to done
    int          e_vcnt;  // cycles mem_valid is high
    logic [31:0] e_rd;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdv, input int dly,
                            output int done_cyc, output logic err_o, output int vcnt,
                            output logic [31:0] c_addr, output logic [3:0] c_strb,
                            output logic [31:0] c_wdata, output logic c_we,
                            output logic stable, output logic busy1, output logic busy_done);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd; mem_rdata = rdv;
    @(negedge clk);
    req = 1'b0;
    done_cyc = -1; err_o = 1'b0; vcnt = 0; stable = 1'b1; busy1 = busy; busy_done = 1'b1;
    c_addr = '0; c_strb = '0; c_wdata = '0; c_we = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (mem_valid) begin
        if (vcnt == 0) begin
          c_addr = mem_addr; c_strb = mem_wstrb; c_wdata = mem_wdata; c_we = mem_we;
        end else if (mem_addr !== c_addr || mem_wstrb !== c_strb ||
                     mem_wdata !== c_wdata || mem_we !== c_we) begin
          stable = 1'b0;
        end
        mem_ready = (dly >= 0 && vcnt == dly);
        vcnt++;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        done_cyc = cyc; err_o = err; busy_done = busy;
        break;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int          dc, vc;
    logic        eo, cwe, stb, b1, bd;
    logic [31:0] ca, cw;
    logic [3:0]  cs;
    logic        seen;

    //         w  f3      addr          wdata         rdata         dly err done vcnt rd_mem        mem_addr      strb     mem_wdata
    vecs[0]  = '{0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 2, 1, 32'hDEAD_BEEF, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[1]  = '{0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 0, 2, 1, 32'hFFFF_FF80, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[2]  = '{0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 0, 2, 1, 32'h0000_0080, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[3]  = '{0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 0, 2, 1, 32'hFFFF_80FF, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[4]  = '{0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 0, 0, 2, 1, 32'h0000_7F01, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[5]  = '{1, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h0,        0, 0, 2, 1, 32'h0000_7F01, 32'h0000_0200, 4'b0010, 32'h7878_7878};
    vecs[6]  = '{1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,        3, 0, 5, 4, 32'h0000_7F01, 32'h0000_0200, 4'b1100, 32'h5678_5678};
    vecs[7]  = '{1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        1, 0, 3, 2, 32'h0000_7F01, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D};
    vecs[8]  = '{0, 3'b010, 32'h0000_0102, 32'h0,        32'hDEAD_BEEF, 0, 1, 2, 0, 32'h0000_7F01, 32'h0,         4'b0000, 32'h0};
    vecs[9]  = '{1, 3'b100, 32'h0000_0200, 32'h1234_5678, 32'h0,        0, 1, 2, 0, 32'h0000_7F01, 32'h0,         4'b0000, 32'h0};
    vecs[10] = '{0, 3'b011, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1, 2, 0, 32'h0000_7F01, 32'h0,         4'b0000, 32'h0};
    vecs[11] = '{0, 3'b001, 32'h0000_0101, 32'h0,        32'hDEAD_BEEF, 0, 1, 2, 0, 32'h0000_7F01, 32'h0,         4'b0000, 32'h0};
    vecs[12] = '{0, 3'b010, 32'h0000_0300, 32'h0,        32'h1122_3344, -1, 1, 6, 5, 32'h0000_7F01, 32'h0000_0300, 4'b0000, 32'h0};
    vecs[13] = '{0, 3'b010, 32'h0000_0300, 32'h0,        32'h1122_3344, 4, 0, 6, 5, 32'h1122_3344, 32'h0000_0300, 4'b0000, 32'h0};
    vecs[14] = '{0, 3'b000, 32'h0000_0301, 32'h0,        32'h1122_3344, 2, 0, 4, 3, 32'h0000_0033, 32'h0000_0300, 4'b0000, 32'h0};
    vecs[15] = '{0, 3'b001, 32'h0000_0300, 32'h0,        32'h1234_8001, 0, 0, 2, 1, 32'hFFFF_8001, 32'h0000_0300, 4'b0000, 32'h0};

    #2 rst_n = 1'b0;
    #1;
    check("reset_ctrl", {27'd0, busy, done, err, mem_valid, mem_we}, 32'd0);
    check("reset_rd_mem", rd_mem, 32'd0);
    check("reset_bus", mem_addr | mem_wdata | {28'd0, mem_wstrb}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_access(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].dly,
                 dc, eo, vc, ca, cs, cw, cwe, stb, b1, bd);
      $display("txn %0d: we=%0d f3=%b addr=%h done_at=%0d err=%0d valid_cycles=%0d rd_mem=%h",
               i, vecs[i].w, vecs[i].f3, vecs[i].a, dc, eo, vc, rd_mem);
      check($sformatf("v%0d_done_cycle", i), dc, vecs[i].e_done);
      check($sformatf("v%0d_err", i), {31'd0, eo}, {31'd0, vecs[i].e_err});
      check($sformatf("v%0d_valid_cycles", i), vc, vecs[i].e_vcnt);
      check($sformatf("v%0d_rd_mem", i), rd_mem, vecs[i].e_rd);
      check($sformatf("v%0d_busy_after_req", i), {31'd0, b1}, 32'd1);
      check($sformatf("v%0d_busy_on_done", i), {31'd0, bd}, 32'd0);
      if (vecs[i].e_vcnt > 0) begin
        check($sformatf("v%0d_mem_addr", i), ca, vecs[i].e_addr);
        check($sformatf("v%0d_wstrb", i), {28'd0, cs}, {28'd0, vecs[i].e_strb});
        check($sformatf("v%0d_mem_we", i), {31'd0, cwe}, {31'd0, vecs[i].w});
        check($sformatf("v%0d_bus_stable", i), {31'd0, stb}, 32'd1);
        if (vecs[i].w) check($sformatf("v%0d_mem_wdata", i), cw, vecs[i].e_wdata);
      end
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
    end

    // req held high through the done cycle: second access starts one cycle later.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("hold_c1_valid", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("hold_c2_done", {31'd0, done}, 32'd1);
    check("hold_c2_valid", {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    check("hold_c3_valid", {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    check("hold_c4_valid", {31'd0, mem_valid}, 32'd1);
    mem_rdata = 32'h0102_0304;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("hold_c5_done", {31'd0, done}, 32'd1);
    check("hold_c5_rd_mem", rd_mem, 32'h0102_0304);
    $display("txn hold: back-to-back req accepted after done, rd_mem=%h", rd_mem);

    // Reset while the bus access is outstanding.
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", {31'd0, mem_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_rd_mem", rd_mem, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("rst_no_done", {31'd0, seen}, 32'd0);
    $display("txn reset: mid-access reset, done_seen=%0d", seen);
    run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0A0B_0C0D, 0,
               dc, eo, vc, ca, cs, cw, cwe, stb, b1, bd);
    $display("txn post_reset: done_at=%0d err=%0d rd_mem=%h", dc, eo, rd_mem);
    check("post_rst_done_cycle", dc, 2);
    check("post_rst_err", {31'd0, eo}, 32'd0);
    check("post_rst_rd_mem", rd_mem, 32'h0A0B_0C0D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
